cache_rd_arbiter: RTL and testbench

//  Shares one memory read channel (AR/R, burst) between two cache refill masters:
//  m0 = icache miss port, m1 = dcache miss port. Holds one outstanding burst at a time,

---
 rtl/cache_rd_arbiter_if.sv | 33 +++
 rtl/cache_rd_arbiter.sv | 139 +++++++++++++
 tb/tb_cache_rd_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_rd_arbiter_if
//  Description : Burst read channel (AR request + R beat stream) between a
//                requester (master) and a responder (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface cache_rd_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 8
);
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [LEN_WIDTH-1:0]  ar_len;
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;

    modport master (
        output ar_valid, ar_addr, ar_len, r_ready,
        input  ar_ready, r_valid, r_data, r_resp, r_last
    );

    modport slave (
        input  ar_valid, ar_addr, ar_len, r_ready,
        output ar_ready, r_valid, r_data, r_resp, r_last
    );
endinterface
`default_nettype wire

// File: rtl/cache_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_rd_arbiter
//  Description : Round-robin arbiter sharing one burst read channel between
//                the icache (m0) and dcache (m1) refill ports, one burst
//                outstanding at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cache_rd_arbiter_if.slave  m0,
    cache_rd_arbiter_if.slave  m1,
    cache_rd_arbiter_if.master s
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t                r_state,      w_state_nxt;
    logic                  r_grant,      w_grant_nxt;
    logic                  r_rr_ptr,     w_rr_ptr_nxt;
    logic                  r_ar_valid,   w_ar_valid_nxt;
    logic [ADDR_WIDTH-1:0] r_ar_addr,    w_ar_addr_nxt;
    logic [LEN_WIDTH-1:0]  r_ar_len,     w_ar_len_nxt;
    logic [LEN_WIDTH-1:0]  r_beats_left, w_beats_left_nxt;
    logic                  w_r_ready;
    logic                  w_beat;

    assign s.ar_valid = r_ar_valid;
    assign s.ar_addr  = r_ar_addr;
    assign s.ar_len   = r_ar_len;
    assign s.r_ready  = w_r_ready;

    // Beat payload is broadcast; only valid/last are steered to the grantee.
    assign m0.r_data = s.r_data;
    assign m1.r_data = s.r_data;
    assign m0.r_resp = s.r_resp;
    assign m1.r_resp = s.r_resp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_rr_ptr     <= 1'b1;
            r_ar_valid   <= 1'b0;
            r_ar_addr    <= '0;
            r_ar_len     <= '0;
            r_beats_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_ar_valid   <= w_ar_valid_nxt;
            r_ar_addr    <= w_ar_addr_nxt;
            r_ar_len     <= w_ar_len_nxt;
            r_beats_left <= w_beats_left_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_ar_valid_nxt   = r_ar_valid;
        w_ar_addr_nxt    = r_ar_addr;
        w_ar_len_nxt     = r_ar_len;
        w_beats_left_nxt = r_beats_left;
        w_r_ready        = 1'b0;
        w_beat           = 1'b0;
        m0.ar_ready      = 1'b0;
        m1.ar_ready      = 1'b0;
        m0.r_valid       = 1'b0;
        m1.r_valid       = 1'b0;
        m0.r_last        = 1'b0;
        m1.r_last        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (m0.ar_valid || m1.ar_valid) begin
                    // On a tie the master that was not served last wins.
                    if (m0.ar_valid && m1.ar_valid)
                        w_grant_nxt = ~r_rr_ptr;
                    else
                        w_grant_nxt = m1.ar_valid;
                    w_ar_addr_nxt  = w_grant_nxt ? m1.ar_addr : m0.ar_addr;
                    w_ar_len_nxt   = w_grant_nxt ? m1.ar_len  : m0.ar_len;
                    w_ar_valid_nxt = 1'b1;
                    w_state_nxt    = S_AR;
                end
            end

            S_AR: begin
                if (r_grant)
                    m1.ar_ready = s.ar_ready;
                else
                    m0.ar_ready = s.ar_ready;
                if (r_ar_valid && s.ar_ready) begin
                    w_ar_valid_nxt   = 1'b0;
                    w_beats_left_nxt = r_ar_len;
                    w_state_nxt      = S_R;
                end
            end

            S_R: begin
                w_r_ready = r_grant ? m1.r_ready : m0.r_ready;
                if (r_grant) begin
                    m1.r_valid = s.r_valid;
                    m1.r_last  = s.r_valid && (r_beats_left == '0);
                end else begin
                    m0.r_valid = s.r_valid;
                    m0.r_last  = s.r_valid && (r_beats_left == '0);
                end
                w_beat = s.r_valid && w_r_ready;
                if (w_beat) begin
                    if (r_beats_left == '0) begin
                        w_rr_ptr_nxt = r_grant;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_beats_left_nxt = r_beats_left - 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_rd_arbiter
//  Description : Randomized self-checking bench for cache_rd_arbiter against a
//                transaction-level model of grants, bursts and beats.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LW = 8;
    localparam int C_BEAT_BUDGET = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) m0_if ();
    cache_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) m1_if ();
    cache_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) s_if ();

    cache_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_if),
        .m1  (m1_if),
        .s   (s_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: outstanding request per master and who was served most recently.
    bit              pend [2];
    logic [AW-1:0]   p_addr [2];
    logic [LW-1:0]   p_len [2];
    bit              last_srv;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic bit pick_winner();
        if (pend[0] && pend[1]) return !last_srv;
        return pend[1];
    endfunction

    function automatic logic [LW-1:0] rand_len();
        case ($urandom_range(0, 7))
            0:       return 8'd0;
            1:       return 8'd255;
            2:       return 8'd1;
            3:       return 8'd3;
            default: return LW'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic drive_masters();
        m0_if.ar_valid = pend[0];
        m0_if.ar_addr  = p_addr[0];
        m0_if.ar_len   = p_len[0];
        m1_if.ar_valid = pend[1];
        m1_if.ar_addr  = p_addr[1];
        m1_if.ar_len   = p_len[1];
    endtask

    task automatic check_quiet(input string ph);
        check({ph, "_r_valid"}, {62'd0, m1_if.r_valid, m0_if.r_valid}, 64'd0);
        check({ph, "_r_last"},  {62'd0, m1_if.r_last,  m0_if.r_last},  64'd0);
        check({ph, "_s_r_ready"}, {63'd0, s_if.r_ready}, 64'd0);
    endtask

    // mode 0: random requests, 1: m0 only at fixed address, 2: both request,
    // 3: both request with len 3 (used for the mid-burst reset case)
    task automatic run_one(input int mode, input int abort_beat);
        bit            w;
        logic [1:0]    onehot;
        logic [AW-1:0] wa;
        logic [LW-1:0] wl;
        int            d, b, cyc;
        bit            rv, rr0, rr1, rdy_w;
        logic [DW-1:0] data;
        logic [1:0]    resp;

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!pend[i]) begin
                bit want;
                case (mode)
                    1:       want = (i == 0);
                    2, 3:    want = 1'b1;
                    default: want = ($urandom_range(0, 2) != 0);
                endcase
                if (want) begin
                    pend[i]   = 1'b1;
                    p_addr[i] = (mode == 1) ? 32'h8000_0010 : $urandom;
                    p_len[i]  = (mode == 1) ? 8'd1 : (mode == 3) ? 8'd3 : rand_len();
                end
            end
        end
        drive_masters();
        s_if.ar_ready = 1'($urandom);
        s_if.r_valid  = 1'($urandom);
        #1;
        check("idle_s_ar_valid", {63'd0, s_if.ar_valid}, 64'd0);
        check("idle_ar_ready", {62'd0, m1_if.ar_ready, m0_if.ar_ready}, 64'd0);
        check_quiet("idle");
        if (!pend[0] && !pend[1]) return;

        w      = pick_winner();
        onehot = w ? 2'b10 : 2'b01;
        wa     = p_addr[w];
        wl     = p_len[w];

        d = $urandom_range(0, 5);
        for (int k = 0; k <= d; k++) begin
            @(negedge clk);
            s_if.ar_ready = (k == d);
            s_if.r_valid  = 1'($urandom);
            #1;
            check("ar_s_valid", {63'd0, s_if.ar_valid}, 64'd1);
            check("ar_s_addr", {32'd0, s_if.ar_addr}, {32'd0, wa});
            check("ar_s_len", {56'd0, s_if.ar_len}, {56'd0, wl});
            check("ar_ready_route", {62'd0, m1_if.ar_ready, m0_if.ar_ready},
                  (k == d) ? {62'd0, onehot} : 64'd0);
            check_quiet("ar");
        end
        pend[w] = 1'b0;

        b   = 0;
        cyc = 0;
        while (b <= int'(wl) && cyc < C_BEAT_BUDGET) begin
            @(negedge clk);
            drive_masters();
            rv   = ($urandom_range(0, 3) != 0);
            rr0  = ($urandom_range(0, 3) != 0);
            rr1  = ($urandom_range(0, 3) != 0);
            data = {$urandom, $urandom};
            resp = 2'($urandom);
            s_if.ar_ready = 1'($urandom);
            s_if.r_valid  = rv;
            s_if.r_data   = data;
            s_if.r_resp   = resp;
            m0_if.r_ready = rr0;
            m1_if.r_ready = rr1;
            if (b == abort_beat) begin
                rst = 1'b0;
                #1;
                check("rst_s_ar_valid", {63'd0, s_if.ar_valid}, 64'd0);
                check("rst_s_ar_addr", {32'd0, s_if.ar_addr}, 64'd0);
                check("rst_s_ar_len", {56'd0, s_if.ar_len}, 64'd0);
                check("rst_ar_ready", {62'd0, m1_if.ar_ready, m0_if.ar_ready}, 64'd0);
                check_quiet("rst");
                pend[0]  = 1'b0;
                pend[1]  = 1'b0;
                last_srv = 1'b1;
                drive_masters();
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            #1;
            rdy_w = w ? rr1 : rr0;
            check("r_valid_route", {62'd0, m1_if.r_valid, m0_if.r_valid},
                  rv ? {62'd0, onehot} : 64'd0);
            check("s_r_ready", {63'd0, s_if.r_ready}, {63'd0, rdy_w});
            check("r_last", {62'd0, m1_if.r_last, m0_if.r_last},
                  (rv && b == int'(wl)) ? {62'd0, onehot} : 64'd0);
            check("r_data_m0", m0_if.r_data, data);
            check("r_data_m1", m1_if.r_data, data);
            check("r_resp", {60'd0, m1_if.r_resp, m0_if.r_resp}, {60'd0, resp, resp});
            check("r_s_ar_valid", {63'd0, s_if.ar_valid}, 64'd0);
            check("r_ar_ready", {62'd0, m1_if.ar_ready, m0_if.ar_ready}, 64'd0);
            if (rv && rdy_w) b++;
            cyc++;
        end
        check("burst_beats", 64'(b), 64'(int'(wl) + 1));
        last_srv = w;
    endtask

    initial begin
        rst = 1'b0;
        pend[0] = 1'b0;  pend[1] = 1'b0;
        p_addr[0] = '0;  p_addr[1] = '0;
        p_len[0]  = '0;  p_len[1]  = '0;
        last_srv  = 1'b1;
        drive_masters();
        m0_if.r_ready = 1'b0;
        m1_if.r_ready = 1'b0;
        s_if.ar_ready = 1'b0;
        s_if.r_valid  = 1'b0;
        s_if.r_data   = '0;
        s_if.r_resp   = '0;
        s_if.r_last   = 1'b0;

        repeat (2) @(negedge clk);
        s_if.ar_ready = 1'b1;
        s_if.r_valid  = 1'b1;
        m0_if.r_ready = 1'b1;
        m1_if.r_ready = 1'b1;
        #1;
        check("reset_s_ar_valid", {63'd0, s_if.ar_valid}, 64'd0);
        check("reset_s_ar_addr", {32'd0, s_if.ar_addr}, 64'd0);
        check("reset_s_ar_len", {56'd0, s_if.ar_len}, 64'd0);
        check("reset_ar_ready", {62'd0, m1_if.ar_ready, m0_if.ar_ready}, 64'd0);
        check_quiet("reset");
        @(negedge clk);
        rst = 1'b1;

        run_one(1, -1);
        for (int i = 0; i < 4; i++) run_one(2, -1);
        for (int i = 0; i < 40; i++) run_one(0, -1);
        run_one(3, 1);
        for (int i = 0; i < 4; i++) run_one(2, -1);
        for (int i = 0; i < 20; i++) run_one(0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
